// File: rtl/br_cmp_sched.sv
// Two-requester round-robin scheduler around a shared branch / set-less-than comparator.
// Pipeline: stage A captures the granted request, stage B holds the resolved response.
module br_cmp_sched #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,

    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [W-1:0] i_req0_rs1,
    input  logic [W-1:0] i_req0_rs2,
    input  logic [2:0]   i_req0_op,

    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [W-1:0] i_req1_rs1,
    input  logic [W-1:0] i_req1_rs2,
    input  logic [2:0]   i_req1_op,

    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic         o_rsp_equal,
    output logic         o_rsp_less,
    output logic         o_rsp_taken
);

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    logic         pri_q, pri_d;

    logic         a_vld_q, a_vld_d;
    logic         a_id_q, a_id_d;
    logic [W-1:0] a_rs1_q, a_rs1_d;
    logic [W-1:0] a_rs2_q, a_rs2_d;
    logic [2:0]   a_op_q, a_op_d;

    logic         b_vld_q, b_vld_d;
    logic         b_id_q, b_id_d;
    logic         b_equal_q, b_equal_d;
    logic         b_less_q, b_less_d;
    logic         b_taken_q, b_taken_d;

    logic         b_adv;
    logic         a_free;
    logic         rdy0;
    logic         rdy1;
    logic         acc0;
    logic         acc1;

    logic         cmp_unsigned;
    logic         cmp_equal;
    logic         cmp_less;
    logic         cmp_taken;

    // Readies never look at their own port's valid; when both ports are valid
    // only the port under the priority pointer is ready.
    always_comb begin
        b_adv  = ~b_vld_q | i_rsp_ready;
        a_free = ~a_vld_q | b_adv;
        rdy0   = i_rst_n & a_free & (~pri_q | ~i_req1_valid);
        rdy1   = i_rst_n & a_free & ( pri_q | ~i_req0_valid);
        acc0   = i_req0_valid & rdy0;
        acc1   = i_req1_valid & rdy1;
    end

    always_comb begin
        cmp_unsigned = (a_op_q == OP_SLTU) | (a_op_q[2:1] == 2'b11);
        cmp_equal    = (a_rs1_q == a_rs2_q);
        if (cmp_unsigned) begin
            cmp_less = (a_rs1_q < a_rs2_q);
        end else begin
            cmp_less = ($signed(a_rs1_q) < $signed(a_rs2_q));
        end
        cmp_taken = 1'b0;
        case (a_op_q)
            OP_BEQ:  cmp_taken = cmp_equal;
            OP_BNE:  cmp_taken = ~cmp_equal;
            OP_SLT:  cmp_taken = cmp_less;
            OP_SLTU: cmp_taken = cmp_less;
            OP_BLT:  cmp_taken = cmp_less;
            OP_BGE:  cmp_taken = ~cmp_less;
            OP_BLTU: cmp_taken = cmp_less;
            OP_BGEU: cmp_taken = ~cmp_less;
            default: cmp_taken = 1'b0;
        endcase
    end

    always_comb begin
        pri_d = pri_q;
        if (acc0) begin
            pri_d = 1'b1;
        end else if (acc1) begin
            pri_d = 1'b0;
        end
    end

    always_comb begin
        a_vld_d = a_vld_q;
        a_id_d  = a_id_q;
        a_rs1_d = a_rs1_q;
        a_rs2_d = a_rs2_q;
        a_op_d  = a_op_q;
        if (a_free) begin
            a_vld_d = acc0 | acc1;
            if (acc1) begin
                a_id_d  = 1'b1;
                a_rs1_d = i_req1_rs1;
                a_rs2_d = i_req1_rs2;
                a_op_d  = i_req1_op;
            end else if (acc0) begin
                a_id_d  = 1'b0;
                a_rs1_d = i_req0_rs1;
                a_rs2_d = i_req0_rs2;
                a_op_d  = i_req0_op;
            end
        end
    end

    // Response fields only change when a new result moves in, so a drained
    // or stalled stage B keeps its last values on the outputs.
    always_comb begin
        b_vld_d   = b_vld_q;
        b_id_d    = b_id_q;
        b_equal_d = b_equal_q;
        b_less_d  = b_less_q;
        b_taken_d = b_taken_q;
        if (b_adv) begin
            b_vld_d = a_vld_q;
            if (a_vld_q) begin
                b_id_d    = a_id_q;
                b_equal_d = cmp_equal;
                b_less_d  = cmp_less;
                b_taken_d = cmp_taken;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pri_q     <= 1'b0;
            a_vld_q   <= 1'b0;
            a_id_q    <= 1'b0;
            a_rs1_q   <= '0;
            a_rs2_q   <= '0;
            a_op_q    <= '0;
            b_vld_q   <= 1'b0;
            b_id_q    <= 1'b0;
            b_equal_q <= 1'b0;
            b_less_q  <= 1'b0;
            b_taken_q <= 1'b0;
        end else begin
            pri_q     <= pri_d;
            a_vld_q   <= a_vld_d;
            a_id_q    <= a_id_d;
            a_rs1_q   <= a_rs1_d;
            a_rs2_q   <= a_rs2_d;
            a_op_q    <= a_op_d;
            b_vld_q   <= b_vld_d;
            b_id_q    <= b_id_d;
            b_equal_q <= b_equal_d;
            b_less_q  <= b_less_d;
            b_taken_q <= b_taken_d;
        end
    end

    assign o_req0_ready = rdy0;
    assign o_req1_ready = rdy1;
    assign o_rsp_valid  = b_vld_q;
    assign o_rsp_id     = b_id_q;
    assign o_rsp_equal  = b_equal_q;
    assign o_rsp_less   = b_less_q;
    assign o_rsp_taken  = b_taken_q;

endmodule

// File: tb/tb_br_cmp_sched.sv
// Scoreboard bench for br_cmp_sched: directed scenarios followed by randomized
// two-port traffic with random response backpressure.
module tb_br_cmp_sched;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0, v1, r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   op0, op1;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_eq, rsp_lt, rsp_tk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic id;
        logic eq;
        logic lt;
        logic tk;
    } rsp_t;

    rsp_t exp_q[$];
    bit   model_pri;
    bit   held;
    rsp_t held_val;

    always #5 clk = ~clk;

    br_cmp_sched #(.W(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (v0),
        .o_req0_ready (r0),
        .i_req0_rs1   (a0),
        .i_req0_rs2   (b0),
        .i_req0_op    (op0),
        .i_req1_valid (v1),
        .o_req1_ready (r1),
        .i_req1_rs1   (a1),
        .i_req1_rs2   (b1),
        .i_req1_op    (op1),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_equal  (rsp_eq),
        .o_rsp_less   (rsp_lt),
        .o_rsp_taken  (rsp_tk)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: compare as mathematical integers after zero/sign extension.
    function automatic rsp_t model(input logic id, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] op);
        rsp_t   r;
        longint sx, sy;
        bit     uns;
        uns = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
        if (uns) begin
            sx = longint'(x);
            sy = longint'(y);
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        r.id = id;
        r.eq = (x == y);
        r.lt = (sx < sy);
        case (op)
            3'd0:       r.tk = r.eq;
            3'd1:       r.tk = !r.eq;
            3'd5, 3'd7: r.tk = !r.lt;
            default:    r.tk = r.lt;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: scoreboard pop on response handshake, push on request accept.
    always @(negedge clk) begin
        rsp_t got;
        rsp_t e;
        if (!rst_n) begin
            exp_q.delete();
            held      = 0;
            model_pri = 0;
        end else begin
            got = '{id: rsp_id, eq: rsp_eq, lt: rsp_lt, tk: rsp_tk};
            if (held) begin
                check("rsp_held_valid", 32'(rsp_valid), 32'd1);
                check("rsp_held_stable", 32'(got), 32'(held_val));
            end
            held     = rsp_valid && !rsp_ready;
            held_val = got;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_fields", 32'(got), 32'(e));
                end
            end
            if (v0 && v1 && ((v0 && r0) || (v1 && r1))) begin
                check("arb_pointer", 32'(v1 && r1), 32'(model_pri));
            end
            if (v0 && r0 && v1 && r1) check("arb_single_accept", 32'd2, 32'd1);
            if (v0 && r0) begin
                exp_q.push_back(model(1'b0, a0, b0, op0));
                model_pri = 1;
            end else if (v1 && r1) begin
                exp_q.push_back(model(1'b1, a1, b1, op1));
                model_pri = 0;
            end
        end
    end

    task automatic issue(input bit port, input logic [2:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (port == 1'b0) begin
            v0 = 1; op0 = op; a0 = x; b0 = y;
        end else begin
            v1 = 1; op1 = op; a1 = x; b1 = y;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!((port == 1'b0) ? r0 : r1) && n < 20);
        check("issue_accept", 32'((port == 1'b0) ? r0 : r1), 32'd1);
        @(posedge clk); #1;
        v0 = 0;
        v1 = 0;
    endtask

    task automatic expect_rsp(input string name, input logic id, input logic eq,
                              input logic lt, input logic tk);
        @(negedge clk);
        check({name, "_not_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_fields"}, {28'd0, rsp_id, rsp_eq, rsp_lt, rsp_tk}, {28'd0, id, eq, lt, tk});
    endtask

    initial begin
        int nacc;
        int n;
        bit acc0, acc1, g;
        rst_n = 0; v0 = 0; v1 = 0; rsp_ready = 1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_readies_low", {30'd0, r0, r1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", {27'd0, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_tk}, 32'd0);
        end
        check("idle_readies", {30'd0, r0, r1}, 32'd3);

        issue(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_rsp("blt_neg1", 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_rsp("bltu_max", 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b011, 32'd5, 32'd5);
        expect_rsp("sltu_eq", 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 3'b000, 32'h8000_0000, 32'h8000_0000);
        expect_rsp("beq_min", 1'b1, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF);
        expect_rsp("slt_extremes", 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        expect_rsp("bgeu_extremes", 1'b1, 1'b0, 1'b0, 1'b1);

        // Contention: pointer is at port 0 after the last port-1 accept.
        @(posedge clk); #1;
        v0 = 1; v1 = 1; op0 = 3'b001; op1 = 3'b101;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("alt_one_ready", 32'(r0 ^ r1), 32'd1);
            check("alt_grant", 32'(r1), 32'(i % 2));
            g = r1;
            @(posedge clk); #1;
            if (g) a1 = W'($urandom); else a0 = W'($urandom);
        end
        v0 = 0; v1 = 0;
        repeat (3) @(posedge clk); #1;

        // Backpressure with port 0 streaming.
        rsp_ready = 0; v0 = 1; op0 = 3'b101; a0 = rnd_opnd(); b0 = rnd_opnd();
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = r0;
            if (g) nacc++;
            if (i >= 2) check("bp_ready_low", 32'(r0), 32'd0);
            @(posedge clk); #1;
            if (g) begin a0 = rnd_opnd(); b0 = rnd_opnd(); end
        end
        check("bp_accept_count", 32'(nacc), 32'd2);
        rsp_ready = 1;
        @(negedge clk);
        check("bp_resume_ready", 32'(r0), 32'd1);
        check("bp_resume_rsp", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        v0 = 0;
        repeat (4) @(posedge clk); #1;

        // Reset with both stages full.
        rsp_ready = 0; v0 = 1; op0 = 3'b000;
        repeat (3) @(posedge clk); #1;
        rst_n = 0; v1 = 1; op1 = 3'b010;
        @(negedge clk);
        check("midrst_readies_low", {30'd0, r0, r1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1; rsp_ready = 1;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_grant0", {30'd0, r0, r1}, 32'd2);
        @(posedge clk); #1;
        v0 = 0;
        @(negedge clk);
        check("midrst_grant1", 32'(r1), 32'd1);
        @(posedge clk); #1;
        v1 = 0;
        repeat (3) @(posedge clk);

        // Randomized traffic; pending requests are held until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = v0 && r0;
            acc1 = v1 && r1;
            @(posedge clk); #1;
            if (!v0 || acc0) begin
                v0 = ($urandom_range(0, 3) != 0);
                op0 = 3'($urandom);
                a0 = rnd_opnd();
                b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd_opnd();
            end
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 3) != 0);
                op1 = 3'($urandom);
                a1 = rnd_opnd();
                b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd_opnd();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        v0 = 0; v1 = 0; rsp_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_rsp_idle", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
